// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the regfile_sb register file.
// The master side is the pipeline and the slave side is the register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] rs;
  logic                           rdEn;
  logic [NUM_READ*DATA_WIDTH-1:0] rdData;
  logic                           RegWrite;
  logic [ADDR_WIDTH-1:0]          rd;
  logic [DATA_WIDTH-1:0]          wrData;
  logic                           issueEn;
  logic [ADDR_WIDTH-1:0]          issueRd;
  logic [(1<<ADDR_WIDTH)-1:0]     busy;
  logic [NUM_READ-1:0]            hazard;
  logic [DATA_WIDTH-1:0]          a0;

  modport master (
    output rs, rdEn, RegWrite, rd, wrData, issueEn, issueRd,
    input  rdData, busy, hazard, a0
  );

  modport slave (
    input  rs, rdEn, RegWrite, rd, wrData, issueEn, issueRd,
    output rdData, busy, hazard, a0
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file: NUM_READ registered read ports, one write port,
// x0 hard-wired to zero, write-to-read bypass, pending-write scoreboard and
// a fixed x10 (a0) debug tap.
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
) (
  input logic          clk,
  input logic          rst_n,
  regfile_sb_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0]          regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]          regs_d [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DEPTH-1:0]               busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]          rs_idx [NUM_READ];
  logic                           wr_en;

  genvar g;
  generate
    for (g = 0; g < NUM_READ; g++) begin : g_rs
      assign rs_idx[g] = bus.rs[g*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  assign wr_en = bus.RegWrite && (bus.rd != '0);

  // Next array contents: single write port, x0 never written.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[bus.rd] = bus.wrData;
    end
    regs_d[0] = '0;
  end

  // Read capture: x0 reads zero, a same-cycle write to the index is bypassed.
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rdEn) begin
      for (int unsigned i = 0; i < NUM_READ; i++) begin
        if (rs_idx[i] == '0) begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else if (bus.RegWrite && (bus.rd == rs_idx[i])) begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.wrData;
        end else begin
          rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rs_idx[i]];
        end
      end
    end
  end

  // Scoreboard: writeback clears, issue sets afterwards so the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[bus.rd] = 1'b0;
    end
    if (bus.issueEn && (bus.issueRd != '0)) begin
      busy_d[bus.issueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Hazard: source pending and not being written back in this cycle.
  always_comb begin
    bus.hazard = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      bus.hazard[i] = (rs_idx[i] != '0) && busy_q[rs_idx[i]] &&
                      !(bus.RegWrite && (bus.rd == rs_idx[i]));
    end
  end

  // All architectural state, read data and scoreboard clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
      busy_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rdData = rd_data_q;
  assign bus.busy   = busy_q;
  assign bus.a0     = regs_q[A0_IDX];
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with NUM_READ registered read ports, one write port, x0 hard-wired to zero, write-to-read bypass, and an integrated pending-write scoreboard for the pipelined core. It sits between decode (read/issue) and writeback (write/clear), replacing the single-cycle two-port file. It adds asynchronous reset of all architectural state and a fixed x10 (a0) debug output.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; file depth is 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rs  in  NUM_READ*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdEn  in  1  read enable; captures all read ports
- rdData  out  NUM_READ*DATA_WIDTH  packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- RegWrite  in  1  writeback strobe
- rd  in  ADDR_WIDTH  writeback index
- wrData  in  DATA_WIDTH  writeback data
- issueEn  in  1  instruction issued with destination issueRd
- issueRd  in  ADDR_WIDTH  destination of issuing instruction
- busy  out  2**ADDR_WIDTH  scoreboard vector, bit n = write to xn pending
- hazard  out  NUM_READ  combinational: port i source is pending and not resolved this cycle
- a0  out  DATA_WIDTH  current contents of x10

## Operation
- Reset (rst_n low, asynchronous): all registers, rdData, busy cleared to 0 immediately; a0 = 0; hazard = 0. Held while rst_n low; first update on first rising edge after release.
- Write: at edge, if RegWrite && rd != 0, reg[rd] <= wrData. rd == 0 writes discarded; x0 reads 0 always.
- Read: at edge, if rdEn, for each port i: rdData[i] <= 0 if rs[i] == 0; else wrData if RegWrite && rd == rs[i]; else reg[rs[i]]. If rdEn low, rdData holds. Reads and writes are independent (same-cycle read and write both occur).
- Multiple ports with same index return identical data.
- Scoreboard, per edge: set bit if issueEn && issueRd != 0; clear bit if RegWrite && rd != 0. Same index set and clear in one cycle: set wins (newer producer). busy[0] constant 0.
- hazard[i] = busy[rs[i]] && !(RegWrite && rd == rs[i]); rs[i] == 0 gives 0. Unaffected by issueEn in the same cycle.
- a0 = reg[10] combinationally from the array (not bypassed).
- Index beyond depth is impossible by width; no range checks.

## Timing
- Write latency: array updated at edge N; a0 and non-bypassed reads reflect it from edge N.
- Read latency: 1 cycle, rdEn sampled at edge, rdData valid after that edge.
- Bypass: write at edge N and read of same index with rdEn at edge N yields wrData on rdData after N.
- Scoreboard: busy changes 1 cycle after issue/writeback; hazard is combinational on current busy, rs, RegWrite, rd.
- Reset asserted mid-operation: outputs go to 0 without waiting for clk; in-flight write or issue at that edge is lost.

## Test plan
- Reset: write x5=0xDEADBEEF, x10=0x12 then pull rst_n low between edges -> rdData, a0, busy all 0 before next edge; read x5 after release -> 0.
- x0: RegWrite rd=0 wrData=0xFFFFFFFF, then read rs0=0 -> rdData port0 = 0; issueEn issueRd=0 -> busy stays 0.
- Bypass: same edge RegWrite rd=7 wrData=0xA5A5A5A5 and rdEn rs0=7 rs1=7 -> both ports 0xA5A5A5A5 after edge; rdEn low next cycle with rs changed -> rdData unchanged.
- Scoreboard: issueEn issueRd=3 -> busy[3]=1 next cycle, rs0=3 gives hazard[0]=1; RegWrite rd=3 cycle -> hazard[0]=0 same cycle, busy[3]=0 after edge.
- Set-wins: busy[4]=1, same edge RegWrite rd=4 and issueEn issueRd=4 -> busy[4] remains 1; reg[4] updated with wrData.
- a0: RegWrite rd=10 wrData=0x0000002A -> a0 = 0x2A after edge; NUM_READ=4 build reads x1..x4 after writes 1..4 -> rdData ports 1,2,3,4.
